// File: rtl/board_ram_arbiter_pkg.sv
// board_ram_arbiter_pkg: shared constants for the board RAM arbiter and its requesters
package board_ram_arbiter_pkg;
    localparam int BRD_ADDR_W  = 8;
    localparam int BRD_DATA_W  = 6;
    localparam int ARB_NUM_REQ = 5;
    localparam int ARB_RD_LAT  = 1;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_HANDOFF = 2'd2;
    localparam int REQ_COLLISION = 0;
    localparam int REQ_COMMIT    = 1;
    localparam int REQ_ROWCLR    = 2;
    localparam int REQ_BOARDCLR  = 3;
    localparam int REQ_DRAWRAM   = 4;
endpackage

// File: rtl/board_ram_arbiter_if.sv
// board_ram_arbiter_if: requester bus plus board RAM port seen by the arbiter
interface board_ram_arbiter_if
    import board_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int ADDR_W  = BRD_ADDR_W,
    parameter int DATA_W  = BRD_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_wren;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         ram_addr;
    logic [DATA_W-1:0]         ram_data;
    logic                      ram_wren;
    logic [DATA_W-1:0]         ram_q;
    logic                      busy;
    modport master (
        output req, req_addr, req_wdata, req_wren, ram_q,
        input  gnt, rvalid, rdata, ram_addr, ram_data, ram_wren, busy
    );
    modport slave (
        input  req, req_addr, req_wdata, req_wren, ram_q,
        output gnt, rvalid, rdata, ram_addr, ram_data, ram_wren, busy
    );
endinterface

// File: rtl/board_ram_arbiter_rr_pick.sv
// board_ram_arbiter_rr_pick: first request at or after the pointer, wrapping, as a one-hot winner
module board_ram_arbiter_rr_pick
    import board_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int PW      = $clog2(ARB_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               any
);
    logic [NUM_REQ-1:0] hi, sel;
    // Prefer requests at or above the pointer, else wrap to the lowest set bit
    always_comb begin
        hi  = req & ({NUM_REQ{1'b1}} << ptr);
        sel = |hi ? hi : req;
        win = sel & (~sel + NUM_REQ'(1));
        any = |req;
    end
endmodule

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: round-robin burst arbiter sharing the single-port board RAM
module board_ram_arbiter
    import board_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int ADDR_W  = BRD_ADDR_W,
    parameter int DATA_W  = BRD_DATA_W,
    parameter int RD_LAT  = ARB_RD_LAT
) (
    input  logic               clk,
    input  logic               reset_n,
    board_ram_arbiter_if.slave bus
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [1:0]         state;
    logic [PW-1:0]      ptr, g_idx;
    logic [NUM_REQ-1:0] gnt, win, issue;
    logic [NUM_REQ-1:0] rd_pipe [RD_LAT];
    logic               any, held, in_grant, wren_mux;
    logic [ADDR_W-1:0]  addr_mux;
    logic [DATA_W-1:0]  data_mux;

    board_ram_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req(bus.req),
        .ptr(ptr),
        .win(win),
        .any(any)
    );

    // Decode the owner index and select its address/data/write-enable slice
    always_comb begin
        g_idx    = '0;
        addr_mux = '0;
        data_mux = '0;
        wren_mux = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                g_idx    = PW'(i);
                addr_mux = bus.req_addr[i*ADDR_W +: ADDR_W];
                data_mux = bus.req_wdata[i*DATA_W +: DATA_W];
                wren_mux = bus.req_wren[i];
            end
        end
    end

    assign in_grant     = state == ST_GRANT;
    assign held         = |(bus.req & gnt);
    assign issue        = in_grant ? gnt & bus.req & ~bus.req_wren : '0;
    assign bus.ram_addr = in_grant ? addr_mux : '0;
    assign bus.ram_data = in_grant ? data_mux : '0;
    assign bus.ram_wren = reset_n & in_grant & held & wren_mux;
    assign bus.gnt      = gnt;
    assign bus.rvalid   = rd_pipe[RD_LAT-1];
    assign bus.rdata    = bus.ram_q;
    assign bus.busy     = state != ST_IDLE;

    // Arbitrate from IDLE, hold the grant for the burst, then one HANDOFF cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= '0;
        end else if (state == ST_IDLE && any) begin
            state <= ST_GRANT;
            gnt   <= win;
        end else if (in_grant && !held) begin
            state <= ST_HANDOFF;
            gnt   <= '0;
            ptr   <= g_idx == PW'(NUM_REQ - 1) ? '0 : g_idx + PW'(1);
        end else if (!in_grant) begin
            state <= ST_IDLE;
        end
    end

    // Carry one-hot read tags alongside the RAM read latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
        end else begin
            rd_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
- Shares the single-port board RAM (ADDR_W × DATA_W, registered read) between the sequencing sub-blocks: collision check, piece commit, row clear, board clear and board redraw.
- Grants one requester at a time and holds that grant for a whole multi-cycle burst.
- Muxes the granted requester's address, write data and write-enable onto the RAM, and returns read data with a valid strobe aligned to RAM latency.
- Sits between the top-level game controller's sub-blocks and the board RAM instance, replacing the per-state RAM mux.

Parameters:
- NUM_REQ, 5, number of requesters; index 0 has highest priority after reset.
- ADDR_W, 8, RAM address width.
- DATA_W, 6, RAM word / colour width.
- RD_LAT, 1, RAM read latency in clocks (1 or 2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester burst request, level; held high for the whole burst
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; slice i belongs to requester i
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_wren  in  NUM_REQ  per-requester write enable
- gnt  out  NUM_REQ  one-hot grant, registered
- rvalid  out  NUM_REQ  one-hot read-data-valid, aligned with rdata
- rdata  out  DATA_W  RAM Q, broadcast to all requesters
- ram_addr  out  ADDR_W  to RAM address
- ram_data  out  DATA_W  to RAM data
- ram_wren  out  1  to RAM write enable
- ram_q  in  DATA_W  from RAM Q
- busy  out  1  high in GRANT or HANDOFF

Behaviour:
- State machine: IDLE, GRANT, HANDOFF. State, gnt and the priority pointer are registered. Async reset puts the FSM in IDLE with gnt=0, rvalid=0, busy=0 and pointer=0.
- IDLE, req≠0:
  - Round-robin pick: first set bit at or after the pointer, wrapping at NUM_REQ-1 → 0.
  - gnt goes one-hot the next cycle and the FSM moves to GRANT.
  - One-cycle grant latency.
- IDLE, req=0: stay; gnt=0.
- GRANT:
  - ram_addr, ram_data and ram_wren are combinational from the granted slice.
  - ram_wren = req_wren[g] & req[g].
  - Grant is locked while req[g]=1; other requests are ignored, with no preemption.
- GRANT, req[g] falls:
  - That cycle is already treated as released: ram_wren forced 0.
  - Next cycle: FSM → HANDOFF, gnt=0, pointer ← (g+1) mod NUM_REQ.
- HANDOFF:
  - Exactly one cycle; ram_wren=0.
  - Prevents a stale registered read leaking to the next owner.
  - Then IDLE, which re-arbitrates normally. Minimum gap between bursts is 2 idle cycles.
- Outside GRANT: ram_addr=0, ram_data=0, ram_wren=0.
- Read tracking:
  - A read issue is a GRANT cycle with req[g]=1 and req_wren[g]=0.
  - A RD_LAT-deep shift register of one-hot issue tags drives rvalid; rvalid[g] rises RD_LAT cycles after issue.
  - rdata=ram_q unregistered.
  - rvalid continues to drain through HANDOFF and IDLE for reads issued before release.
- Writes never produce rvalid.
- Simultaneous requests from IDLE after reset: lowest index wins.
- A requester may drop and re-raise req; it rejoins arbitration after HANDOFF, behind others per the pointer.
- reset_n asserted mid-burst: immediate IDLE, gnt=0, ram_wren=0, read shift register cleared. No write may occur in the reset cycle.
- gnt is never more than one-hot; ram_wren is never high while gnt=0.

Decomposition:
- Shared package holds:
  - Arbiter state encoding (IDLE, GRANT, HANDOFF).
  - Board RAM ADDR_W/DATA_W constants.
  - Requester index constants: REQ_COLLISION=0, REQ_COMMIT=1, REQ_ROWCLR=2, REQ_BOARDCLR=3, REQ_DRAWRAM=4.
- One natural sub-module, rr_pick: combinational round-robin priority encoder (req, pointer → one-hot winner, any).

Test Plan:
- Reset then req=5'b00001, addr0=8'd17, wren0=0 for 3 cycles:
  - gnt=00001 one cycle later.
  - ram_addr=17 while granted.
  - rvalid[0] pulses RD_LAT after each of the 3 read cycles, rdata=preloaded value.
  - HANDOFF, then IDLE.
- req=5'b11000 asserted together from IDLE:
  - gnt=01000 first.
  - After req[3] drops: HANDOFF, then gnt=10000.
  - Requester 4 sees no rvalid for requester 3's reads.
- Round-robin fairness, req held at 5'b00011 with bursts of 4 cycles each:
  - Grant order 0,1,0,1.
  - Each burst preceded by 2 non-granted cycles.
- Write burst, requester 2 writes data 6'h2A to addrs 0..9, then requester 4 reads 0..9:
  - All reads return 6'h2A.
  - ram_wren never high during HANDOFF.
- reset_n low for 1 cycle mid-write burst of requester 1:
  - ram_wren=0 and gnt=0 in the same cycle.
  - rvalid cleared.
  - After release, arbitration restarts with pointer=0.
- req[g] dropped the same cycle wren high:
  - ram_wren=0 that cycle.
  - No write reaches RAM (check target address unchanged).
